// File: rtl/pll_seq_pkg.sv
// State encoding and sizing helpers shared by the PLL lock sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } pll_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Counter width able to hold n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchroniser bringing the raw PLL LOCK into the reference clock domain.
module pll_lock_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_p0;
  logic sync_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      meta_p0 <= d;
      sync_p1 <= meta_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/pll_lock_sequencer.sv
// SB_PLL40_CORE reset/lock sequencer with retry, fault and loss counting.
// Optional build macro PLL_BYPASS_FALLBACK_EN: FAULT routes the reference clock via BYPASS and releases sys_reset.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RESET_CYCLES  = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 3,
  parameter int CNT_W         = 8
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             pll_locked,
  input  logic             restart,
  output logic             pll_resetb,
  output logic             pll_bypass,
  output logic             sys_reset,
  output logic             ready,
  output logic             fault,
  output logic             lock_lost,
  output logic [CNT_W-1:0] loss_count,
  output logic [2:0]       state_o
);

  localparam int CW = cnt_width(max3(RESET_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES));
  localparam int RW = cnt_width(MAX_RETRIES + 1);
  localparam logic [CW-1:0] RST_LAST = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STB_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

`ifdef PLL_BYPASS_FALLBACK_EN
  localparam bit FALLBACK = 1'b1;
`else
  localparam bit FALLBACK = 1'b0;
`endif

  logic             lk;
  pll_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic [CNT_W-1:0] loss_q, loss_d;
  logic             lost_d;

  pll_lock_sync u_lock_sync (
    .clk (clock_in),
    .rst (reset),
    .d   (pll_locked),
    .q   (lk)
  );

  // restart overrides every transition; lock loss is checked before completion
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    loss_d  = loss_q;
    lost_d  = 1'b0;
    if (restart) begin
      state_d = RESET_PLL;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        RESET_PLL: begin
          if (cnt_q == RST_LAST) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        WAIT_LOCK: begin
          if (lk) begin
            state_d = STABLE;
            cnt_d   = '0;
          end else if (cnt_q == TO_LAST) begin
            cnt_d = '0;
            if (retry_q < RETRY_MAX) begin
              retry_d = retry_q + 1'b1;
              state_d = RESET_PLL;
            end else begin
              state_d = FAULT;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        STABLE: begin
          if (!lk) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == STB_LAST) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RUN: begin
          retry_d = '0;
          if (!lk) begin
            lost_d  = 1'b1;
            state_d = RESET_PLL;
            cnt_d   = '0;
            if (loss_q != '1) loss_d = loss_q + 1'b1;
          end
        end
        FAULT: begin
          state_d = FAULT;
        end
        default: begin
          state_d = RESET_PLL;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      state_q    <= RESET_PLL;
      cnt_q      <= '0;
      retry_q    <= '0;
      loss_q     <= '0;
      pll_resetb <= 1'b0;
      sys_reset  <= 1'b1;
      ready      <= 1'b0;
      fault      <= 1'b0;
      lock_lost  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      retry_q    <= retry_d;
      loss_q     <= loss_d;
      pll_resetb <= !((state_d == RESET_PLL) || (state_d == FAULT));
      sys_reset  <= !((state_d == RUN) || (FALLBACK && (state_d == FAULT)));
      ready      <= (state_d == RUN);
      fault      <= (state_d == FAULT);
      lock_lost  <= lost_d;
    end
  end

`ifdef PLL_BYPASS_FALLBACK_EN
  always_ff @(posedge clock_in) begin
    if (reset) pll_bypass <= 1'b0;
    else       pll_bypass <= (state_d == FAULT);
  end
`else
  assign pll_bypass = 1'b0;
`endif

  assign loss_count = loss_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer (RESET_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2).
module tb_pll_lock_sequencer;

  localparam int RC = 4;
  localparam int LT = 20;
  localparam int SC = 8;
  localparam int MR = 2;
  localparam int CW = 8;
`ifdef PLL_BYPASS_FALLBACK_EN
  localparam bit FB = 1'b1;
`else
  localparam bit FB = 1'b0;
`endif

  logic          clock_in = 1'b0;
  logic          reset, pll_locked, restart;
  logic          pll_resetb, pll_bypass, sys_reset, ready, fault, lock_lost;
  logic [CW-1:0] loss_count;
  logic [2:0]    state_o;

  int n_cmp = 0;
  int n_bad = 0;

  pll_lock_sequencer #(
    .RESET_CYCLES (RC),
    .LOCK_TIMEOUT (LT),
    .STABLE_CYCLES(SC),
    .MAX_RETRIES  (MR),
    .CNT_W        (CW)
  ) dut (
    .clock_in  (clock_in),
    .reset     (reset),
    .pll_locked(pll_locked),
    .restart   (restart),
    .pll_resetb(pll_resetb),
    .pll_bypass(pll_bypass),
    .sys_reset (sys_reset),
    .ready     (ready),
    .fault     (fault),
    .lock_lost (lock_lost),
    .loss_count(loss_count),
    .state_o   (state_o)
  );

  always #5 clock_in = ~clock_in;

  typedef struct {
    logic locked;
    logic rs;
    int   cyc;
    int   st;
    logic rb;
    logic rdy;
    logic lost;
    int   loss;
  } vec_t;

  vec_t vecs[$];
  vec_t v;

  function automatic vec_t mk(input logic locked, input logic rs, input int cyc, input int st,
                              input logic rb, input logic rdy, input logic lost, input int loss);
    vec_t r;
    r.locked = locked; r.rs = rs; r.cyc = cyc; r.st = st;
    r.rb = rb; r.rdy = rdy; r.lost = lost; r.loss = loss;
    return r;
  endfunction

  task automatic tick();
    @(posedge clock_in);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rb_edge, rdy_edge, sr_edge, pulses, exp_loss;
    bit got;

    // Stimulus table: from RUN with loss_count=0.
    // lock drop of 5 raw cycles -> loss, 4-cycle PLL reset, relock
    vecs.push_back(mk(0, 0, 2, 3, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 1, 1, 1, 0, 0, 1));
    vecs.push_back(mk(1, 0, 1, 2, 1, 0, 0, 1));
    vecs.push_back(mk(1, 0, 7, 2, 1, 0, 0, 1));
    vecs.push_back(mk(1, 0, 1, 3, 1, 1, 0, 1));
    // restart from RUN, then a one-cycle glitch mid-STABLE
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 3, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 1, 1, 1, 0, 0, 1));
    vecs.push_back(mk(1, 0, 2, 2, 1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 2, 1, 0, 0, 1));
    vecs.push_back(mk(1, 0, 1, 2, 1, 0, 0, 1));
    vecs.push_back(mk(1, 0, 1, 1, 1, 0, 0, 1));
    vecs.push_back(mk(1, 0, 1, 2, 1, 0, 0, 1));
    vecs.push_back(mk(1, 0, 7, 2, 1, 0, 0, 1));
    vecs.push_back(mk(1, 0, 1, 3, 1, 1, 0, 1));
    // lock drop on the cycle STABLE would complete
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 4, 1, 1, 0, 0, 1));
    vecs.push_back(mk(1, 0, 6, 2, 1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 2, 2, 1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 1, 1, 0, 0, 1));
    vecs.push_back(mk(1, 0, 3, 2, 1, 0, 0, 1));
    vecs.push_back(mk(1, 0, 8, 3, 1, 1, 0, 1));
    // restart on the cycle the lock loss would be seen in RUN
    vecs.push_back(mk(0, 0, 2, 3, 1, 1, 0, 1));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 1));
    // no lock: three attempts of 4+20 cycles, then FAULT
    vecs.push_back(mk(0, 0, 4, 1, 1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 19, 1, 1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 47, 1, 1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 4, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 10, 4, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 4, 1, 1, 0, 0, 1));
    vecs.push_back(mk(1, 0, 9, 3, 1, 1, 0, 1));

    reset = 1'b1; pll_locked = 1'b1; restart = 1'b0;
    repeat (3) tick();
    chk("rst.pll_resetb", pll_resetb, 0);
    chk("rst.pll_bypass", pll_bypass, 0);
    chk("rst.sys_reset", sys_reset, 1);
    chk("rst.ready", ready, 0);
    chk("rst.fault", fault, 0);
    chk("rst.lock_lost", lock_lost, 0);
    chk("rst.loss_count", loss_count, 0);
    chk("rst.state", state_o, 0);

    // Power-up with lock held high: measure edge numbers after reset release.
    reset = 1'b0;
    rb_edge = -1; rdy_edge = -1; sr_edge = -1;
    for (int e = 1; e <= 60; e++) begin
      tick();
      if (rb_edge < 0 && pll_resetb) rb_edge = e;
      if (sr_edge < 0 && !sys_reset) sr_edge = e;
      if (rdy_edge < 0 && ready) begin
        rdy_edge = e;
        break;
      end
    end
    chk("pwrup.resetb_rise_edge", rb_edge, RC);
    chk("pwrup.ready_rise_edge", rdy_edge, RC + 1 + SC);
    chk("pwrup.sysrst_fall_edge", sr_edge, RC + 1 + SC);
    chk("pwrup.state", state_o, 3);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      pll_locked = v.locked;
      restart = v.rs;
      repeat (v.cyc) tick();
      restart = 1'b0;
      chk($sformatf("v%0d.state", i), state_o, v.st);
      chk($sformatf("v%0d.pll_resetb", i), pll_resetb, v.rb);
      chk($sformatf("v%0d.ready", i), ready, v.rdy);
      chk($sformatf("v%0d.lock_lost", i), lock_lost, v.lost);
      chk($sformatf("v%0d.loss_count", i), loss_count, v.loss);
      chk($sformatf("v%0d.fault", i), fault, (v.st == 4));
      chk($sformatf("v%0d.sys_reset", i), sys_reset, !((v.st == 3) || (FB && v.st == 4)));
      chk($sformatf("v%0d.pll_bypass", i), pll_bypass, (FB && v.st == 4));
    end

    // Force 2^CW more losses on top of the one already counted: count saturates.
    exp_loss = 1;
    for (int k = 0; k < (1 << CW); k++) begin
      pll_locked = 1'b0;
      tick();
      pll_locked = 1'b1;
      pulses = 0;
      got = 1'b0;
      for (int c = 0; c < 40; c++) begin
        tick();
        if (lock_lost) begin
          pulses++;
          got = 1'b1;
        end
        if (got && ready) break;
      end
      if (exp_loss < (1 << CW) - 1) exp_loss++;
      chk($sformatf("sat%0d.pulses", k), pulses, 1);
      chk($sformatf("sat%0d.relock", k), ready, 1);
      chk($sformatf("sat%0d.loss_count", k), loss_count, exp_loss);
    end
    chk("sat.final_all_ones", loss_count, (1 << CW) - 1);

    // Reset mid-sequence (in STABLE) clears everything, loss_count included.
    restart = 1'b1;
    tick();
    restart = 1'b0;
    repeat (6) tick();
    chk("midrst.pre_state", state_o, 2);
    reset = 1'b1;
    tick();
    chk("midrst.state", state_o, 0);
    chk("midrst.loss_count", loss_count, 0);
    chk("midrst.pll_resetb", pll_resetb, 0);
    chk("midrst.sys_reset", sys_reset, 1);
    chk("midrst.ready", ready, 0);
    reset = 1'b0;
    repeat (RC) tick();
    chk("midrst.resetb_after", pll_resetb, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
